// File: rtl/iqdemap_pkg.sv
// Shared types and constants for the IQ demapper write scheduler.
// Holds the scheduler state encoding and the lane index constants.
package iqdemap_pkg;

  localparam int IQ_DATA_W = 128;

  localparam logic LANE_BPSK = 1'b0;
  localparam logic LANE_QPSK = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_ACK,
    DONE
  } state_t;

endpackage

// File: rtl/iqdemap_lane_buf.sv
// One-word holding buffer for a demapper lane.
// A load on a full buffer is dropped unless the word is cleared the same cycle.
module iqdemap_lane_buf
  import iqdemap_pkg::*;
#(
  parameter int W = IQ_DATA_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         clr,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic         full,
  output logic [W-1:0] q,
  output logic         drop
);

  assign drop = load & full & ~clr & ~flush;

  always_ff @(posedge CLK) begin
    if (RST) begin
      full <= 1'b0;
      q    <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load && (!full || clr)) begin
      full <= 1'b1;
      q    <= d;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/iqdemap_wr_sched.sv
// Write scheduler: two lane buffers, arbiter and req/ack writer port.
// Define IQDEMAP_WR_SCHED_FIXED_PRIO_EN for fixed lane-0 priority.
module iqdemap_wr_sched
  import iqdemap_pkg::*;
#(
  parameter int DATA_W      = IQ_DATA_W,
  parameter int ADDR_W      = 10,
  parameter int FRAME_WORDS = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ce,
  input  logic              start,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam logic [ADDR_W:0] LAST = FRAME_WORDS[ADDR_W:0];

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   cnt_inc;
  logic              gnt_q, gnt_d;
  logic              sel;
  logic              sel_both;

  logic              wr_req_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              busy_d;
  logic              done_d;
  logic              overflow_d;

  logic              capture;
  logic              ack_ok;
  logic              flush;
  logic              ld0, ld1;
  logic              clr0, clr1;
  logic              full0, full1;
  logic              drop0, drop1;
  logic [DATA_W-1:0] q0, q1;

  assign capture = (state_q == RUN) || (state_q == WAIT_ACK);
  assign ack_ok  = (state_q == WAIT_ACK) && wr_ack;
  assign flush   = (state_q == DONE);
  assign ld0     = capture & ce & in0_valid;
  assign ld1     = capture & ce & in1_valid;
  assign clr0    = ack_ok & (gnt_q == LANE_BPSK);
  assign clr1    = ack_ok & (gnt_q == LANE_QPSK);
  assign cnt_inc = cnt_q + 1'b1;

  iqdemap_lane_buf #(.W(DATA_W)) u_buf0 (
    .CLK   (CLK),
    .RST   (RST),
    .load  (ld0),
    .clr   (clr0),
    .flush (flush),
    .d     (in0_data),
    .full  (full0),
    .q     (q0),
    .drop  (drop0)
  );

  iqdemap_lane_buf #(.W(DATA_W)) u_buf1 (
    .CLK   (CLK),
    .RST   (RST),
    .load  (ld1),
    .clr   (clr1),
    .flush (flush),
    .d     (in1_data),
    .full  (full1),
    .q     (q1),
    .drop  (drop1)
  );

`ifdef IQDEMAP_WR_SCHED_FIXED_PRIO_EN
  assign sel_both = LANE_BPSK;
`else
  logic rr_q, rr_d;

  assign sel_both = rr_q;

  // Pointer names the lane that wins the next tie.
  always_ff @(posedge CLK) begin
    if (RST) rr_q <= LANE_BPSK;
    else     rr_q <= rr_d;
  end

  always_comb begin
    rr_d = rr_q;
    if (ack_ok) rr_d = ~gnt_q;
  end
`endif

  always_comb begin
    sel = LANE_BPSK;
    unique case (1'b1)
      full0 & ~full1: sel = LANE_BPSK;
      ~full0 & full1: sel = LANE_QPSK;
      full0 & full1:  sel = sel_both;
      default:        sel = LANE_BPSK;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      gnt_q    <= LANE_BPSK;
      wr_req   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      wr_req   <= wr_req_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      busy     <= busy_d;
      done     <= done_d;
      overflow <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    wr_req_d   = wr_req;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    busy_d     = busy;
    done_d     = 1'b0;
    overflow_d = overflow | drop0 | drop1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d     = '0;
          cnt_d      = '0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (full0 || full1) begin
          gnt_d     = sel;
          wr_data_d = sel ? q1 : q0;
          wr_addr_d = addr_q;
          wr_req_d  = 1'b1;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          addr_d   = addr_q + 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_inc == LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
